// File: rtl/keyscan_pkg.sv
// keyscan_pkg: shared types, constants and key decode helpers
// for the 4x4 matrix keypad scanner.
package keyscan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam logic [15:0] KEY_NONE    = 16'h0000;
    localparam logic [7:0]  ASCII_DIGIT = 8'h30;
    localparam logic [7:0]  ASCII_ALPHA = 8'h41;
    localparam logic [3:0]  COLS_IDLE   = 4'hF;

    // Lowest-numbered low column; walk downward so the lowest wins.
    function automatic logic [1:0] low_col(input logic [3:0] cols);
        logic [1:0] c;
        c = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) begin
                c = 2'(i);
            end
        end
        return c;
    endfunction

    // Key index (row*4+col) to ASCII: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] key_ascii(input logic [3:0] idx);
        logic [7:0] a;
        if (idx < 4'd10) begin
            a = ASCII_DIGIT + {4'd0, idx};
        end else begin
            a = ASCII_ALPHA + {4'd0, idx} - 8'd10;
        end
        return a;
    endfunction

endpackage

// File: rtl/keyscan_sync.sv
// keyscan_sync: 4-bit two-flop synchronizer for the column lines,
// resetting to the idle (all pulled-up) pattern.
module keyscan_sync
    import keyscan_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Two-stage capture of the asynchronous column inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= COLS_IDLE;
            q    <= COLS_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keyscan.sv
// keyscan: 4x4 active-low keypad scanner with debounce, ASCII key register.
// Optional macro KEYSCAN_LATCH_EN keeps the last key until a CPU read (rd).
module keyscan
    import keyscan_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col_in,
    input  logic        rd,
    output logic [3:0]  row_sel,
    output logic [15:0] key_code,
    output logic        key_strobe
);

`ifdef KEYSCAN_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    localparam int MAX_DIV = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t        state, state_n;
    logic [1:0]    row, row_n;
    logic [CW-1:0] scan_cnt, scan_cnt_n;
    logic [CW-1:0] db_cnt, db_cnt_n;
    logic [3:0]    cap, cap_n;
    logic [15:0]   code_q, code_n;
    logic          strobe_q, strobe_n;
    logic [3:0]    col_s;

    // Saturating increment so counters never wrap.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] x);
        return (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    keyscan_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_in),
        .q     (col_s)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_SCAN;
            row      <= 2'd0;
            scan_cnt <= '0;
            db_cnt   <= '0;
            cap      <= COLS_IDLE;
            code_q   <= KEY_NONE;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            scan_cnt <= scan_cnt_n;
            db_cnt   <= db_cnt_n;
            cap      <= cap_n;
            code_q   <= code_n;
            strobe_q <= strobe_n;
        end
    end

    // Next-state logic: scan rows, debounce a press, wait for full release.
    always_comb begin
        state_n    = state;
        row_n      = row;
        scan_cnt_n = scan_cnt;
        db_cnt_n   = db_cnt;
        cap_n      = cap;
        code_n     = code_q;
        strobe_n   = 1'b0;

        // A read clears a latched key; a same-cycle acceptance below overrides.
        if (LATCH && rd) begin
            code_n = KEY_NONE;
        end

        unique case (state)
            ST_SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (col_s == COLS_IDLE) begin
                        row_n = row + 2'd1;
                    end else begin
                        cap_n    = col_s;
                        db_cnt_n = '0;
                        state_n  = ST_DEBOUNCE;
                    end
                end else begin
                    scan_cnt_n = cnt_inc(scan_cnt);
                end
            end

            ST_DEBOUNCE: begin
                if (col_s != cap) begin
                    state_n    = ST_SCAN;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                end else if (db_cnt == DB_LAST) begin
                    code_n   = {8'h00, key_ascii({row, low_col(cap)})};
                    strobe_n = 1'b1;
                    db_cnt_n = '0;
                    state_n  = ST_HELD;
                end else begin
                    db_cnt_n = cnt_inc(db_cnt);
                end
            end

            ST_HELD: begin
                if (col_s != COLS_IDLE) begin
                    db_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n    = ST_SCAN;
                    row_n      = row + 2'd1;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                    if (!LATCH) begin
                        code_n = KEY_NONE;
                    end
                end else begin
                    db_cnt_n = cnt_inc(db_cnt);
                end
            end

            default: begin
                state_n = ST_SCAN;
            end
        endcase
    end

    assign row_sel    = ~(4'b0001 << row);
    assign key_code   = code_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keyscan.sv
// tb_keyscan: directed self-checking bench for keyscan with
// SCAN_DIV=4, DEBOUNCE_CNT=8 and a behavioural keypad model.
module tb_keyscan;

    localparam int SD = 4;
    localparam int DC = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_sel;
    logic [15:0] key_code;
    logic        key_strobe;

    logic [3:0]  key_mask = 4'h0;
    logic [1:0]  key_row = 2'd0;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    keyscan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clock      (clock),
        .reset      (reset),
        .col_in     (col_in),
        .rd         (rd),
        .row_sel    (row_sel),
        .key_code   (key_code),
        .key_strobe (key_strobe)
    );

    always #5 clock = ~clock;

    // Keypad: pressed columns pull low only while their row is driven.
    assign col_in = (row_sel[key_row] == 1'b0) ? ~key_mask : 4'hF;

    always @(posedge clock) begin
        if (key_strobe === 1'b1) strobes++;
    end

    task automatic wait_strobe(output int cyc, output bit seen);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (key_strobe === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_mask = 4'h0;
        repeat (3) @(negedge clock);
        checks++;
        if (row_sel !== 4'b1110) begin
            errors++;
            $display("FAIL reset_row_sel: got %b expected %b", row_sel, 4'b1110);
        end
        checks++;
        if (key_code !== 16'h0000) begin
            errors++;
            $display("FAIL reset_key_code: got %h expected %h", key_code, 16'h0);
        end
        checks++;
        if (key_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe: got %b expected 0", key_strobe);
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp;
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            exp = ~(4'b0001 << ((k / SD) % 4));
            checks++;
            if (row_sel !== exp) begin
                errors++;
                $display("FAIL idle_row_sel[%0d]: got %b expected %b", k, row_sel, exp);
            end
        end
        checks++;
        if (key_code !== 16'h0000) begin
            errors++;
            $display("FAIL idle_key_code: got %h expected 0000", key_code);
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL idle_strobes: got %0d expected 0", strobes);
        end
    endtask

    task automatic test_press(input logic [1:0] r, input logic [3:0] m,
                              input logic [15:0] exp, input string name);
        int cyc;
        int n;
        int s0;
        bit seen;
        s0 = strobes;
        key_row = r;
        key_mask = m;
        wait_strobe(cyc, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no strobe in %0d cycles", name, cyc);
        end else begin
            checks++;
            if (key_code !== exp) begin
                errors++;
                $display("FAIL %s_code: got %h expected %h", name, key_code, exp);
            end
            @(negedge clock);
            checks++;
            if (key_strobe !== 1'b0 || key_code !== exp) begin
                errors++;
                $display("FAIL %s_after: strobe %b code %h expected 0 %h",
                         name, key_strobe, key_code, exp);
            end
        end
        repeat (5) @(negedge clock);
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL %s_count: got %0d strobes expected 1", name, strobes - s0);
        end
        key_mask = 4'h0;
`ifdef KEYSCAN_LATCH_EN
        repeat (15) @(negedge clock);
        checks++;
        if (key_code !== exp) begin
            errors++;
            $display("FAIL %s_latched: got %h expected %h", name, key_code, exp);
        end
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
        checks++;
        if (key_code !== 16'h0000) begin
            errors++;
            $display("FAIL %s_rd_clear: got %h expected 0000", name, key_code);
        end
`else
        n = 0;
        while (key_code !== 16'h0000 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 2 + DC) begin
            errors++;
            $display("FAIL %s_release: got %0d cycles expected %0d", name, n, 2 + DC);
        end
`endif
        repeat (3) @(negedge clock);
    endtask

    task automatic test_bounce();
        int cyc;
        int s0;
        bit seen;
        s0 = strobes;
        key_row = 2'd2;
        for (int i = 0; i < 40; i++) begin
            key_mask = (((i / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
            @(negedge clock);
        end
        checks++;
        if (strobes != s0) begin
            errors++;
            $display("FAIL bounce_early: got %0d strobes expected 0", strobes - s0);
        end
        key_mask = 4'b0001;
        wait_strobe(cyc, seen);
        checks++;
        if (!seen || cyc < 3 + DC) begin
            errors++;
            $display("FAIL bounce_latency: seen %b after %0d cycles expected >= %0d",
                     seen, cyc, 3 + DC);
        end
        checks++;
        if (key_code !== 16'h0038) begin
            errors++;
            $display("FAIL bounce_code: got %h expected 0038", key_code);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d strobes expected 1", strobes - s0);
        end
        key_mask = 4'h0;
        repeat (15) @(negedge clock);
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_rd_during_press();
        int cyc;
        bit seen;
        logic [15:0] exp_next;
        key_row = 2'd0;
        key_mask = 4'b0100;
        rd = 1'b1;
        wait_strobe(cyc, seen);
        checks++;
        if (!seen || key_code !== 16'h0032) begin
            errors++;
            $display("FAIL rd_accept: seen %b code %h expected 1 0032", seen, key_code);
        end
        @(negedge clock);
        rd = 1'b0;
`ifdef KEYSCAN_LATCH_EN
        exp_next = 16'h0000;
`else
        exp_next = 16'h0032;
`endif
        checks++;
        if (key_code !== exp_next) begin
            errors++;
            $display("FAIL rd_after: got %h expected %h", key_code, exp_next);
        end
        key_mask = 4'h0;
        repeat (15) @(negedge clock);
        checks++;
        if (key_code !== 16'h0000) begin
            errors++;
            $display("FAIL rd_release: got %h expected 0000", key_code);
        end
    endtask

    task automatic test_reset_held();
        int cyc;
        int s0;
        bit seen;
        key_row = 2'd1;
        key_mask = 4'b0010;
        wait_strobe(cyc, seen);
        checks++;
        if (!seen || key_code !== 16'h0035) begin
            errors++;
            $display("FAIL held_code: seen %b code %h expected 1 0035", seen, key_code);
        end
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (key_code !== 16'h0000 || row_sel !== 4'b1110 || key_strobe !== 1'b0) begin
            errors++;
            $display("FAIL held_reset: code %h row %b strobe %b expected 0000 1110 0",
                     key_code, row_sel, key_strobe);
        end
        key_mask = 4'h0;
        repeat (3) @(negedge clock);
        s0 = strobes;
        reset = 1'b0;
        repeat (30) @(negedge clock);
        checks++;
        if (strobes != s0 || key_code !== 16'h0000) begin
            errors++;
            $display("FAIL held_post_reset: strobes %0d code %h expected 0 0000",
                     strobes - s0, key_code);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press(2'd1, 4'b0100, 16'h0036, "key6");
        test_press(2'd3, 4'b1000, 16'h0046, "keyF");
        test_press(2'd2, 4'b0100, 16'h0041, "keyA");
        test_press(2'd0, 4'b1010, 16'h0031, "multi");
        test_press(2'd1, 4'b0010, 16'h0035, "key5");
        test_bounce();
        test_rd_during_press();
        test_reset_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
